// File: rtl/vram_pkg.sv
// Shared types and helpers for the dual-port Wishbone VRAM.
// Used by vram_wb_port and vram_dp_wb (optional macro VRAM_ERR_EN).
package vram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } vram_state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 2;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit latency_legal(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/vram_wb_port.sv
// One Wishbone B3 classic slave port: FSM, accept latch, ACK/ERR generation, lane-masked read data.
// VRAM_ERR_EN adds o_err and flags out-of-range addresses; otherwise addresses wrap modulo DEPTH_WORDS.
module vram_wb_port
    import vram_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int DEPTH_WORDS = 8192,
    parameter int LATENCY     = 1,
    parameter int IDX_W       = 13
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_sel,
    input  logic [ADDR_W:1]       i_adr,
    input  logic [DATA_W-1:0]     i_q,
    output logic                  o_acc,
    output logic                  o_wr,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_ack,
`ifdef VRAM_ERR_EN
    output logic                  o_err,
`endif
    output logic [DATA_W-1:0]     o_dat
);

    localparam int LANES = lane_count(DATA_W);

    vram_state_e          r_state;
    vram_state_e          w_next;
    logic                 r_we;
    logic [LANES-1:0]     r_sel;
    logic [DATA_W-1:0]    r_q_p1;
    logic [DATA_W-1:0]    w_q;
    logic                 w_bus;
    logic                 w_live;
    int unsigned          w_adr_n;
    int unsigned          w_idx_n;
`ifdef VRAM_ERR_EN
    logic                 w_oor;
    logic                 r_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_bus  = i_cyc & i_stb;
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_bus) w_next = (LATENCY == 2) ? ST_WAIT : ST_ACK;
            ST_WAIT: w_next = w_bus ? ST_ACK : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request attributes are frozen at accept; writes commit on that same edge in the top.
    always_ff @(posedge i_clk) begin
        if (o_acc) begin
            r_we  <= i_we;
            r_sel <= i_sel;
`ifdef VRAM_ERR_EN
            r_err <= w_oor;
`endif
        end
        r_q_p1 <= i_q;
    end

    always_comb begin
        o_acc   = (r_state == ST_IDLE) & w_bus & ~i_rst;
        w_adr_n = 32'(i_adr);
`ifdef VRAM_ERR_EN
        w_oor   = (w_adr_n >= 32'(DEPTH_WORDS));
        w_idx_n = w_oor ? 32'd0 : w_adr_n;
        o_wr    = o_acc & i_we & ~w_oor;
`else
        w_idx_n = w_adr_n % 32'(DEPTH_WORDS);
        o_wr    = o_acc & i_we;
`endif
        o_idx   = IDX_W'(w_idx_n);
    end

    // Outputs drop immediately if the master abandons the cycle or reset arrives.
    always_comb begin
        w_live = (r_state == ST_ACK) & w_bus & ~i_rst;
        w_q    = (LATENCY == 2) ? r_q_p1 : i_q;
`ifdef VRAM_ERR_EN
        o_ack  = w_live & ~r_err;
        o_err  = w_live & r_err;
`else
        o_ack  = w_live;
`endif
        o_dat  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (o_ack & ~r_we & r_sel[l]) o_dat[8*l +: 8] = w_q[8*l +: 8];
        end
    end

endmodule

// File: rtl/vram_dp_wb.sv
// True-dual-port VRAM with two Wishbone B3 classic slave ports (A: CPU, B: video fetch).
// Define VRAM_ERR_EN to get A_ERR_O/B_ERR_O for out-of-range addresses instead of wrapping.
module vram_dp_wb
    import vram_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int DEPTH_WORDS = 8192,
    parameter int LATENCY     = 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  A_CYC_I,
    input  logic                  A_STB_I,
    input  logic                  A_WE_I,
    input  logic [DATA_W/8-1:0]   A_SEL_I,
    input  logic [ADDR_W:1]       A_ADR_I,
    input  logic [DATA_W-1:0]     A_DAT_I,
    output logic [DATA_W-1:0]     A_DAT_O,
    output logic                  A_ACK_O,
`ifdef VRAM_ERR_EN
    output logic                  A_ERR_O,
    output logic                  B_ERR_O,
`endif
    input  logic                  B_CYC_I,
    input  logic                  B_STB_I,
    input  logic                  B_WE_I,
    input  logic [DATA_W/8-1:0]   B_SEL_I,
    input  logic [ADDR_W:1]       B_ADR_I,
    input  logic [DATA_W-1:0]     B_DAT_I,
    output logic [DATA_W-1:0]     B_DAT_O,
    output logic                  B_ACK_O
);

    localparam int  LANES  = lane_count(DATA_W);
    localparam int  IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit  LAT_OK = latency_legal(LATENCY);
    localparam int  LAT    = LAT_OK ? LATENCY : LATENCY_MIN;

    logic             w_a_acc, w_a_wr, w_b_acc, w_b_wr;
    logic [IDX_W-1:0] w_a_idx, w_b_idx;
    logic [DATA_W-1:0] w_a_q, w_b_q;

    vram_wb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS),
                   .LATENCY(LAT), .IDX_W(IDX_W)) u_port_a (
        .i_clk(CLK_I), .i_rst(RST_I), .i_cyc(A_CYC_I), .i_stb(A_STB_I),
        .i_we(A_WE_I), .i_sel(A_SEL_I), .i_adr(A_ADR_I), .i_q(w_a_q),
        .o_acc(w_a_acc), .o_wr(w_a_wr), .o_idx(w_a_idx), .o_ack(A_ACK_O),
`ifdef VRAM_ERR_EN
        .o_err(A_ERR_O),
`endif
        .o_dat(A_DAT_O)
    );

    vram_wb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS),
                   .LATENCY(LAT), .IDX_W(IDX_W)) u_port_b (
        .i_clk(CLK_I), .i_rst(RST_I), .i_cyc(B_CYC_I), .i_stb(B_STB_I),
        .i_we(B_WE_I), .i_sel(B_SEL_I), .i_adr(B_ADR_I), .i_q(w_b_q),
        .o_acc(w_b_acc), .o_wr(w_b_wr), .o_idx(w_b_idx), .o_ack(B_ACK_O),
`ifdef VRAM_ERR_EN
        .o_err(B_ERR_O),
`endif
        .o_dat(B_DAT_O)
    );

    // Reads use pre-edge contents (read-first); port A's write is ordered last so it wins shared lanes.
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_a_q;
        logic [7:0] r_b_q;

        always_ff @(posedge CLK_I) begin
            if (w_a_acc) r_a_q <= r_mem[w_a_idx];
            if (w_b_acc) r_b_q <= r_mem[w_b_idx];
            if (w_b_wr && B_SEL_I[gl]) r_mem[w_b_idx] <= B_DAT_I[8*gl +: 8];
            if (w_a_wr && A_SEL_I[gl]) r_mem[w_a_idx] <= A_DAT_I[8*gl +: 8];
        end

        assign w_a_q[8*gl +: 8] = r_a_q;
        assign w_b_q[8*gl +: 8] = r_b_q;
    end

endmodule

// File: tb/tb_vram_dp_wb.sv
// Directed bench for vram_dp_wb: word-level reference model, per-cycle output compare, literal pins.
// Works with or without VRAM_ERR_EN defined.
module tb_vram_dp_wb;

    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int DEPTH = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic          a_cyc = 0, a_stb = 0, a_we = 0, b_cyc = 0, b_stb = 0, b_we = 0;
    logic [1:0]    a_sel = 0, b_sel = 0;
    logic [AW:1]   a_adr = 0, b_adr = 0;
    logic [DW-1:0] a_dat = 0, b_dat = 0, a_dato, b_dato;
    logic          a_ack, b_ack;

    logic          c_cyc = 0, c_stb = 0, c_we = 0, d_cyc = 0, d_stb = 0, d_we = 0;
    logic [1:0]    c_sel = 0, d_sel = 0;
    logic [AW:1]   c_adr = 0, d_adr = 0;
    logic [DW-1:0] c_dat = 0, d_dat = 0, c_dato, d_dato;
    logic          c_ack, d_ack;
`ifdef VRAM_ERR_EN
    logic          a_err, b_err, c_err, d_err;
`endif

    vram_dp_wb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut (
        .CLK_I(clk), .RST_I(rst),
        .A_CYC_I(a_cyc), .A_STB_I(a_stb), .A_WE_I(a_we), .A_SEL_I(a_sel),
        .A_ADR_I(a_adr), .A_DAT_I(a_dat), .A_DAT_O(a_dato), .A_ACK_O(a_ack),
`ifdef VRAM_ERR_EN
        .A_ERR_O(a_err), .B_ERR_O(b_err),
`endif
        .B_CYC_I(b_cyc), .B_STB_I(b_stb), .B_WE_I(b_we), .B_SEL_I(b_sel),
        .B_ADR_I(b_adr), .B_DAT_I(b_dat), .B_DAT_O(b_dato), .B_ACK_O(b_ack)
    );

    vram_dp_wb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
        .CLK_I(clk), .RST_I(rst),
        .A_CYC_I(c_cyc), .A_STB_I(c_stb), .A_WE_I(c_we), .A_SEL_I(c_sel),
        .A_ADR_I(c_adr), .A_DAT_I(c_dat), .A_DAT_O(c_dato), .A_ACK_O(c_ack),
`ifdef VRAM_ERR_EN
        .A_ERR_O(c_err), .B_ERR_O(d_err),
`endif
        .B_CYC_I(d_cyc), .B_STB_I(d_stb), .B_WE_I(d_we), .B_SEL_I(d_sel),
        .B_ADR_I(d_adr), .B_DAT_I(d_dat), .B_DAT_O(d_dato), .B_ACK_O(d_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Expected per-cycle outputs, written by the transaction tasks from the model.
    logic          exp_a_ack = 0, exp_b_ack = 0, exp_a_err = 0, exp_b_err = 0, exp_c_ack = 0;
    logic [DW-1:0] exp_a_dat = 0, exp_b_dat = 0, exp_c_dat = 0;
    bit            cmp_en = 0;

    // Reference memories: whole words, indexed by effective word address.
    logic [15:0] m1 [int];
    logic [15:0] m2 [int];

    function automatic logic [15:0] lmask(input logic [1:0] s);
        return {{8{s[1]}}, {8{s[0]}}};
    endfunction
    function automatic logic [15:0] rd1(input int i);
        return m1.exists(i) ? m1[i] : 16'h0000;
    endfunction
    function automatic logic [15:0] rd2(input int i);
        return m2.exists(i) ? m2[i] : 16'h0000;
    endfunction

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("a_ack", 32'(a_ack), 32'(exp_a_ack));
                chk("a_dat", 32'(a_dato), 32'(exp_a_dat));
                chk("b_ack", 32'(b_ack), 32'(exp_b_ack));
                chk("b_dat", 32'(b_dato), 32'(exp_b_dat));
                chk("c_ack", 32'(c_ack), 32'(exp_c_ack));
                chk("c_dat", 32'(c_dato), 32'(exp_c_dat));
                chk("d_ack", 32'(d_ack), 32'd0);
                chk("d_dat", 32'(d_dato), 32'd0);
`ifdef VRAM_ERR_EN
                chk("a_err", 32'(a_err), 32'(exp_a_err));
                chk("b_err", 32'(b_err), 32'(exp_b_err));
                chk("c_err", 32'(c_err), 32'd0);
                chk("d_err", 32'(d_err), 32'd0);
`endif
            end
        end
    end

    // One access on each enabled port of the LATENCY=1 instance, all accepted on the same edge.
    task automatic txn1(input logic ae, input logic awe, input logic [1:0] asel, input int aadr,
                        input logic [15:0] adat,
                        input logic be, input logic bwe, input logic [1:0] bsel, input int badr,
                        input logic [15:0] bdat,
                        output logic [15:0] ard, output logic [15:0] brd);
        logic          aerr, berr;
        logic [15:0]   ea, eb;
        int            ai, bi;
        ai   = aadr % DEPTH;
        bi   = badr % DEPTH;
        aerr = 1'b0;
        berr = 1'b0;
`ifdef VRAM_ERR_EN
        aerr = ae && (aadr >= DEPTH);
        berr = be && (badr >= DEPTH);
`endif
        ea = (ae && !awe && !aerr) ? (rd1(ai) & lmask(asel)) : 16'h0000;
        eb = (be && !bwe && !berr) ? (rd1(bi) & lmask(bsel)) : 16'h0000;
        if (be && bwe && !berr) m1[bi] = (rd1(bi) & ~lmask(bsel)) | (bdat & lmask(bsel));
        if (ae && awe && !aerr) m1[ai] = (rd1(ai) & ~lmask(asel)) | (adat & lmask(asel));

        @(posedge clk); #1;
        a_cyc = ae; a_stb = ae; a_we = awe; a_sel = asel; a_adr = AW'(aadr); a_dat = adat;
        b_cyc = be; b_stb = be; b_we = bwe; b_sel = bsel; b_adr = AW'(badr); b_dat = bdat;
        @(posedge clk); #1;
        exp_a_ack = ae && !aerr; exp_a_err = aerr; exp_a_dat = ea;
        exp_b_ack = be && !berr; exp_b_err = berr; exp_b_dat = eb;
        @(negedge clk);
        ard = a_dato;
        brd = b_dato;
        @(posedge clk); #1;
        a_cyc = 0; a_stb = 0; a_we = 0; b_cyc = 0; b_stb = 0; b_we = 0;
        exp_a_ack = 0; exp_a_err = 0; exp_a_dat = 0;
        exp_b_ack = 0; exp_b_err = 0; exp_b_dat = 0;
    endtask

    // One access on port A of the LATENCY=2 instance; drop abandons it in the wait cycle.
    task automatic txn2(input logic we, input logic [1:0] sel, input int adr, input logic [15:0] dat,
                        input logic drop, output logic [15:0] rd);
        logic [15:0] e;
        e = (!we) ? (rd2(adr) & lmask(sel)) : 16'h0000;
        if (we) m2[adr] = (rd2(adr) & ~lmask(sel)) | (dat & lmask(sel));
        @(posedge clk); #1;
        c_cyc = 1; c_stb = 1; c_we = we; c_sel = sel; c_adr = AW'(adr); c_dat = dat;
        @(posedge clk); #1;
        if (drop) begin
            c_cyc = 0; c_stb = 0;
        end
        @(posedge clk); #1;
        if (!drop) begin
            exp_c_ack = 1; exp_c_dat = e;
        end
        @(negedge clk);
        rd = c_dato;
        @(posedge clk); #1;
        c_cyc = 0; c_stb = 0; c_we = 0;
        exp_c_ack = 0; exp_c_dat = 0;
    endtask

    initial begin
        logic [15:0] ra, rb;
        repeat (3) @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("reset_a_ack", 32'(a_ack), 32'd0);
        chk("reset_b_dat", 32'(b_dato), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        txn1(1, 1, 2'b11, 0, 16'h0F0F, 0, 0, 2'b00, 0, 16'h0, ra, rb);

        txn1(1, 1, 2'b11, 'h10, 16'hBEEF, 0, 0, 2'b00, 0, 16'h0, ra, rb);
        chk("t1_write_dat", 32'(ra), 32'h0000);
        txn1(1, 0, 2'b11, 'h10, 16'h0, 0, 0, 2'b00, 0, 16'h0, ra, rb);
        chk("t1_read", 32'(ra), 32'hBEEF);

        txn1(0, 0, 2'b00, 0, 16'h0, 1, 1, 2'b01, 'h10, 16'h1234, ra, rb);
        txn1(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b11, 'h10, 16'h0, ra, rb);
        chk("t2_read_11", 32'(rb), 32'hBE34);
        txn1(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b10, 'h10, 16'h0, ra, rb);
        chk("t2_read_10", 32'(rb), 32'hBE00);

        txn1(1, 1, 2'b10, 'h20, 16'hAAAA, 1, 1, 2'b11, 'h20, 16'h5555, ra, rb);
        txn1(1, 0, 2'b11, 'h20, 16'h0, 0, 0, 2'b00, 0, 16'h0, ra, rb);
        chk("t3_collide_ww", 32'(ra), 32'hAA55);

        txn1(1, 0, 2'b11, 'h10, 16'h0, 1, 1, 2'b11, 'h10, 16'h9999, ra, rb);
        chk("t3_read_first", 32'(ra), 32'hBE34);
        txn1(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b11, 'h10, 16'h0, ra, rb);
        chk("t3_after_rw", 32'(rb), 32'h9999);

        txn2(1, 2'b11, 'h30, 16'hC3C3, 0, ra);
        txn2(0, 2'b11, 'h30, 16'h0, 0, ra);
        chk("t4_lat2_read", 32'(ra), 32'hC3C3);
        txn2(0, 2'b11, 'h30, 16'h0, 1, ra);
        chk("t4_dropped", 32'(ra), 32'h0000);
        txn2(0, 2'b01, 'h30, 16'h0, 0, ra);
        chk("t4_after_drop", 32'(ra), 32'h00C3);

        txn1(1, 1, 2'b11, DEPTH, 16'h5A5A, 0, 0, 2'b00, 0, 16'h0, ra, rb);
        txn1(1, 0, 2'b11, 0, 16'h0, 0, 0, 2'b00, 0, 16'h0, ra, rb);
`ifdef VRAM_ERR_EN
        chk("t5_no_wrap", 32'(ra), 32'h0F0F);
`else
        chk("t5_wrap", 32'(ra), 32'h5A5A);
`endif

        m1['h40] = 16'h7777;
        @(posedge clk); #1;
        a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 2'b11; a_adr = AW'('h40); a_dat = 16'h7777;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("t6_rst_ack", 32'(a_ack), 32'd0);
        chk("t6_rst_dat", 32'(a_dato), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        a_cyc = 0; a_stb = 0; a_we = 0;
        txn1(1, 0, 2'b11, 'h40, 16'h0, 0, 0, 2'b00, 0, 16'h0, ra, rb);
        chk("t6_committed", 32'(ra), 32'h7777);

        repeat (2) @(posedge clk);
        cmp_en = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
